// File: rtl/gate_input_debouncer_pkg.sv
// Shared types and defaults for the two-channel gate input conditioner.
// Optional edge pulses are enabled with macro DEBOUNCE_EDGE_PULSE_EN.
package gate_cond_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } deb_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/gate_input_debouncer_if.sv
// Raw/clean signal bundle between the pin side and the AND gate consumer.
// Edge-pulse signals exist only when DEBOUNCE_EDGE_PULSE_EN is defined.
interface gate_input_debouncer_if;
  logic a_raw;
  logic b_raw;
  logic a_clean;
  logic b_clean;
  logic stable;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic a_rise;
  logic a_fall;
  logic b_rise;
  logic b_fall;

  modport master (output a_raw, b_raw,
                  input  a_clean, b_clean, stable, a_rise, a_fall, b_rise, b_fall);
  modport slave  (input  a_raw, b_raw,
                  output a_clean, b_clean, stable, a_rise, a_fall, b_rise, b_fall);
`else
  modport master (output a_raw, b_raw, input  a_clean, b_clean, stable);
  modport slave  (input  a_raw, b_raw, output a_clean, b_clean, stable);
`endif
endinterface

// File: rtl/gate_input_debouncer_channel.sv
// One debounce channel: 2-flop synchroniser, 4-state FSM with hold counter.
// DEBOUNCE_EDGE_PULSE_EN adds registered one-cycle rise/fall pulses.
module debounce_channel
  import gate_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_clean,
  output logic o_settled
`ifdef DEBOUNCE_EDGE_PULSE_EN
  ,
  output logic o_rise,
  output logic o_fall
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_s1, r_s2;
  deb_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  assign w_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Counter only runs in the two checking states and stops at CNT_LAST.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_LOW: begin
        if (r_s2) begin
          w_state_nxt = S_RISE;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt = '0;
        end
      end
      S_RISE: begin
        if (!r_s2) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
        end else if (w_last) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!r_s2) begin
          w_state_nxt = S_FALL;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      S_FALL: begin
        if (r_s2) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
        end else if (w_last) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Pure decode of the state flops; S_HIGH/S_FALL share bit 1 so clean is a flop bit.
  always_comb begin
    o_clean   = (r_state == S_HIGH) || (r_state == S_FALL);
    o_settled = (r_state == S_LOW)  || (r_state == S_HIGH);
  end

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic r_rise, r_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= (r_state == S_RISE) && (w_state_nxt == S_HIGH);
      r_fall <= (r_state == S_FALL) && (w_state_nxt == S_LOW);
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;
`endif

endmodule

// File: rtl/gate_input_debouncer.sv
// Two independent debounce channels feeding the AND gate's A/B inputs.
// DEBOUNCE_EDGE_PULSE_EN exposes per-channel rise/fall pulses on the interface.
module gate_input_debouncer
  import gate_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  gate_input_debouncer_if.slave bus
);

  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0] w_raw, w_clean, w_settled;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic [NUM_CH-1:0] w_rise, w_fall;
`endif

  assign w_raw = {bus.b_raw, bus.a_raw};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_raw    (w_raw[g]),
      .o_clean  (w_clean[g]),
      .o_settled(w_settled[g])
`ifdef DEBOUNCE_EDGE_PULSE_EN
      ,
      .o_rise   (w_rise[g]),
      .o_fall   (w_fall[g])
`endif
    );
  end

  assign bus.a_clean = w_clean[0];
  assign bus.b_clean = w_clean[1];
  assign bus.stable  = &w_settled;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  assign bus.a_rise = w_rise[0];
  assign bus.a_fall = w_fall[0];
  assign bus.b_rise = w_rise[1];
  assign bus.b_fall = w_fall[1];
`endif

endmodule

// File: tb/tb_gate_input_debouncer.sv
// Bench for gate_input_debouncer: directed latency/reset cases plus random bouncing
// stimulus against a window-based reference (DEBOUNCE_EDGE_PULSE_EN checks pulses too).
module tb_gate_input_debouncer;

  localparam int DC = 4;
  localparam logic [15:0] WMASK = 16'((1 << DC) - 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gate_input_debouncer_if dif();

  gate_input_debouncer #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: raw reaches the checker two edges late; clean flips once the last
  // DC samples all disagree with it; a channel is settled when its newest sample agrees.
  bit          m_s1 [2];
  bit          m_s2 [2];
  logic [15:0] m_win [2];
  bit          m_clean [2];
  bit          m_settled [2];
  bit          m_rise [2];
  bit          m_fall [2];

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_win[c] = '0;
      m_clean[c] = 0; m_settled[c] = 1; m_rise[c] = 0; m_fall[c] = 0;
    end
  endfunction

  function automatic void model_edge(input bit a, input bit b);
    bit raw [2];
    bit samp;
    raw[0] = a; raw[1] = b;
    for (int c = 0; c < 2; c++) begin
      samp = m_s2[c];
      m_s2[c] = m_s1[c];
      m_s1[c] = raw[c];
      m_win[c] = {m_win[c][14:0], samp};
      m_rise[c] = 0;
      m_fall[c] = 0;
      if ((m_win[c] & WMASK) == (m_clean[c] ? 16'h0 : WMASK)) begin
        m_clean[c] = !m_clean[c];
        m_rise[c]  = m_clean[c];
        m_fall[c]  = !m_clean[c];
      end
      m_settled[c] = (samp == m_clean[c]);
    end
  endfunction

  task automatic check_outputs(input string ph);
    chk({ph, ".a_clean"}, 32'(dif.a_clean), 32'(m_clean[0]));
    chk({ph, ".b_clean"}, 32'(dif.b_clean), 32'(m_clean[1]));
    chk({ph, ".stable"},  32'(dif.stable),  32'(m_settled[0] && m_settled[1]));
`ifdef DEBOUNCE_EDGE_PULSE_EN
    chk({ph, ".a_rise"}, 32'(dif.a_rise), 32'(m_rise[0]));
    chk({ph, ".a_fall"}, 32'(dif.a_fall), 32'(m_fall[0]));
    chk({ph, ".b_rise"}, 32'(dif.b_rise), 32'(m_rise[1]));
    chk({ph, ".b_fall"}, 32'(dif.b_fall), 32'(m_fall[1]));
`endif
  endtask

  // Called just after a falling edge: drive raw, take one rising edge, check.
  task automatic cyc(input bit a, input bit b, input string ph);
    dif.a_raw = a;
    dif.b_raw = b;
    @(posedge clk);
    model_edge(a, b);
    @(negedge clk);
    check_outputs(ph);
  endtask

  int lat;
  int hold_a, hold_b;
  bit ra, rb;
  bit saw_a;

  initial begin
    rst = 1'b1;
    dif.a_raw = 1'b0;
    dif.b_raw = 1'b0;
    model_reset();
    #1;
    chk("rst.a_clean", 32'(dif.a_clean), 32'd0);
    chk("rst.b_clean", 32'(dif.b_clean), 32'd0);
    chk("rst.stable",  32'(dif.stable),  32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) cyc(0, 0, "idle");

    // a_raw rises before edge 1: clean after edge 6, stable low after edges 3..5
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      cyc(1, 0, "lat");
      if (k >= 3 && k <= 5) chk("lat.stable_low", 32'(dif.stable), 32'd0);
      if (dif.a_clean) lat = k;
    end
    chk("lat.a_rise_edge", 32'(lat), 32'(DC + 2));
    for (int k = 0; k < 3; k++) cyc(1, 0, "hi");

    // asynchronous reset while a_clean=1
    chk("pre_rst.a_clean", 32'(dif.a_clean), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst.a_clean", 32'(dif.a_clean), 32'd0);
    chk("arst.stable",  32'(dif.stable),  32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    dif.a_raw = 1'b0;
    for (int k = 0; k < 6; k++) cyc(0, 0, "post_rst");

    // short pulse of 3 cycles is filtered
    saw_a = 0;
    for (int k = 0; k < 3; k++) begin cyc(1, 0, "glitch"); saw_a |= dif.a_clean; end
    for (int k = 0; k < 8; k++) begin cyc(0, 0, "glitch"); saw_a |= dif.a_clean; end
    chk("glitch.a_never", 32'(saw_a), 32'd0);

    // b bounces 1,0,1,1,0 then the final 0->1 and hold
    cyc(0, 1, "bounce"); cyc(0, 0, "bounce"); cyc(0, 1, "bounce");
    cyc(0, 1, "bounce"); cyc(0, 0, "bounce");
    chk("bounce.b_early", 32'(dif.b_clean), 32'd0);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      cyc(0, 1, "bounce");
      if (dif.b_clean) lat = k;
    end
    chk("bounce.b_rise_edge", 32'(lat), 32'(DC + 2));
    for (int k = 0; k < 10; k++) cyc(0, 0, "drop");

    // simultaneous rise
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      cyc(1, 1, "both");
      chk("both.same", 32'(dif.a_clean), 32'(dif.b_clean));
      if (dif.a_clean) begin
        lat = k;
        chk("both.stable", 32'(dif.stable), 32'd1);
      end
    end
    chk("both.rise_edge", 32'(lat), 32'(DC + 2));

    // falling edge of a (pulse outputs compared by the model when enabled)
    for (int k = 0; k < 10; k++) cyc(0, 1, "a_fall");
    chk("a_fall.a_clean", 32'(dif.a_clean), 32'd0);

    // random bouncing, hold lengths straddling DC
    hold_a = 0; hold_b = 0; ra = 0; rb = 1;
    for (int k = 0; k < 1500; k++) begin
      if (hold_a == 0) begin ra = 1'($urandom); hold_a = $urandom_range(1, 2 * DC + 2); end
      if (hold_b == 0) begin rb = 1'($urandom); hold_b = $urandom_range(1, 2 * DC + 2); end
      if ($urandom_range(0, 15) == 0) begin rb = ra; hold_b = hold_a; end
      cyc(ra, rb, "rand");
      hold_a--; hold_b--;
      if (k == 700) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rand_rst");
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
